// File: rtl/wb_arbiter_if.sv
// Purpose: bundles the writeback arbiter's request, issue, status and register-file signals.
// Latency: none (signal bundle only).
// Backpressure: only the M request path is flow-controlled, through m_ready.
interface wb_arbiter_if;
  // pipeline (P) writeback request, never backpressured
  logic        p_valid;
  logic [4:0]  p_dest;
  logic [31:0] p_data;
  // multi-cycle unit (M) writeback request
  logic        m_valid;
  logic [4:0]  m_dest;
  logic [31:0] m_data;
  logic        m_ready;
  // M operation issue, marks its destination as outstanding
  logic        issue_valid;
  logic [4:0]  issue_dest;
  // status back to the pipeline
  logic [31:0] pending;
  logic        p_stall;
  logic        err;
  // register file write port
  logic        rf_load;
  logic [4:0]  rf_dest;
  logic [31:0] rf_in;

  // requesters: pipeline, multi-cycle unit and issue logic
  modport master (
    output p_valid, p_dest, p_data,
    output m_valid, m_dest, m_data,
    output issue_valid, issue_dest,
    input  m_ready, pending, p_stall, err,
    input  rf_load, rf_dest, rf_in
  );

  // the arbiter itself
  modport slave (
    input  p_valid, p_dest, p_data,
    input  m_valid, m_dest, m_data,
    input  issue_valid, issue_dest,
    output m_ready, pending, p_stall, err,
    output rf_load, rf_dest, rf_in
  );
endinterface

// File: rtl/wb_arbiter.sv
// Purpose: arbitrates pipeline (P) and multi-cycle (M) writebacks onto one register-file write port.
// Latency: P request to rf_load 1 cycle; M request to rf_load at least 2 cycles (2-entry FIFO).
// Backpressure: P never backpressured but throttled by a one-cycle p_stall; M held off by m_ready when FIFO full.
module wb_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input logic        clk,
  input logic        rst_n,
  wb_arbiter_if.slave bus
);

  // Starvation threshold in the counter's own width (legal range 1..15).
  localparam logic [4:0] STARVE_LIM = 5'(STARVE_MAX);

  typedef struct packed {
    logic [4:0]  dest;
    logic [31:0] data;
  } wr_req_t;

  // ---------------------------------------------------------------
  // State
  // ---------------------------------------------------------------
  wr_req_t     fifo_mem [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  fifo_cnt;
  logic        ready_en;      // low in reset, high from the first edge after release
  logic [3:0]  starve_cnt;
  logic        p_stall_q;
  logic        rf_load_q;
  logic [4:0]  rf_dest_q;
  logic [31:0] rf_in_q;
  logic [31:0] pending_q;
  logic        err_q;

  // ---------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------
  logic        fifo_full;
  logic        fifo_empty;
  logic        m_ready_int;
  logic        push;
  logic        p_sel;
  logic        m_sel;
  wr_req_t     head;
  logic        p_violation;
  logic        issue_set;
  logic        issue_dup;
  logic        m_orphan;
  logic        head_blocked;
  logic [4:0]  starve_inc;
  logic [31:0] pending_next;

  assign fifo_full   = (fifo_cnt == 2'd2);
  assign fifo_empty  = (fifo_cnt == 2'd0);
  // Full blocks acceptance even when the head pops this cycle, so the
  // FIFO never sees push and pop together while full.
  assign m_ready_int = ready_en && !fifo_full;
  // dest=0 requests are acknowledged but never buffered.
  assign push        = bus.m_valid && m_ready_int && (bus.m_dest != 5'd0);

  assign head        = fifo_mem[rd_ptr];
  // P wins unless it targets r0 or the pipeline is being throttled;
  // otherwise the buffered M head drains.
  assign p_sel       = bus.p_valid && (bus.p_dest != 5'd0) && !p_stall_q;
  assign m_sel       = !p_sel && !fifo_empty;
  assign head_blocked = !fifo_empty && !m_sel;
  assign starve_inc  = {1'b0, starve_cnt} + 5'd1;

  // Protocol checks feeding the sticky error flag.
  assign p_violation = bus.p_valid && (bus.p_dest != 5'd0) && p_stall_q;
  assign issue_set   = bus.issue_valid && (bus.issue_dest != 5'd0);
  assign issue_dup   = issue_set && pending_q[bus.issue_dest];
  assign m_orphan    = m_sel && !pending_q[head.dest];

  // Next pending mask: M commit clears, a same-cycle issue re-sets (set wins); r0 never pending.
  always_comb begin
    pending_next = pending_q;
    if (m_sel) begin
      pending_next[head.dest] = 1'b0;
    end
    if (issue_set) begin
      pending_next[bus.issue_dest] = 1'b1;
    end
    pending_next[0] = 1'b0;
  end

  // ---------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------

  // Enable M acceptance from the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
    end
  end

  // FIFO pointers and occupancy; the head pops exactly when selected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (m_sel) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, m_sel})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // FIFO storage; contents are meaningless while the count says empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{dest: bus.m_dest, data: bus.m_data};
    end
  end

  // Starvation counter: one-cycle p_stall after STARVE_MAX blocked head cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= 4'd0;
      p_stall_q  <= 1'b0;
    end else if (head_blocked) begin
      if (starve_inc == STARVE_LIM) begin
        starve_cnt <= 4'd0;
        p_stall_q  <= 1'b1;
      end else begin
        starve_cnt <= starve_inc[3:0];
        p_stall_q  <= 1'b0;
      end
    end else begin
      // empty FIFO or a pop this cycle
      starve_cnt <= 4'd0;
      p_stall_q  <= 1'b0;
    end
  end

  // Register-file write port: registered winner, address/data held while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_load_q <= 1'b0;
      rf_dest_q <= 5'd0;
      rf_in_q   <= 32'd0;
    end else if (p_sel) begin
      rf_load_q <= 1'b1;
      rf_dest_q <= bus.p_dest;
      rf_in_q   <= bus.p_data;
    end else if (m_sel) begin
      rf_load_q <= 1'b1;
      rf_dest_q <= head.dest;
      rf_in_q   <= head.data;
    end else begin
      rf_load_q <= 1'b0;
    end
  end

  // Outstanding-write mask and sticky protocol error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_next;
      if (p_violation || issue_dup || m_orphan) begin
        err_q <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------
  assign bus.m_ready = m_ready_int;
  assign bus.pending = pending_q;
  assign bus.p_stall = p_stall_q;
  assign bus.err     = err_q;
  assign bus.rf_load = rf_load_q;
  assign bus.rf_dest = rf_dest_q;
  assign bus.rf_in   = rf_in_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Purpose: directed plus randomized checking of wb_arbiter against a queue-based reference model.
// Latency: model predicts every registered output one cycle ahead and compares each cycle.
// Backpressure: M requests are held until the model says they were accepted.
module tb_wb_arbiter;
  localparam int SM = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_arbiter_if bus ();
  wb_arbiter #(.STARVE_MAX(SM)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [4:0]  dest;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];        // buffered M writes, oldest first
  int          blk;          // consecutive cycles the oldest M write waited
  bit          stall_m;
  logic [31:0] pend_m;
  bit          err_m;
  bit          load_m;
  logic [4:0]  dest_m;
  logic [31:0] in_m;
  bit          live_m;       // out of reset for at least one edge
  bit          acc_m;        // M request accepted on the last edge

  function automatic bit exp_mready();
    return live_m && (mq.size() < 2);
  endfunction

  task automatic model_reset();
    mq.delete();
    blk = 0; stall_m = 0; pend_m = '0; err_m = 0;
    load_m = 0; dest_m = '0; in_m = '0; live_m = 0; acc_m = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit had, popped, p_ok;
    ent_t h;
    logic [31:0] np;
    p_ok   = bus.p_valid && bus.p_dest != 0 && !stall_m;
    acc_m  = bus.m_valid && exp_mready();
    had    = mq.size() > 0;
    popped = 0;
    np     = pend_m;
    if (bus.issue_valid && bus.issue_dest != 0 && pend_m[bus.issue_dest]) err_m = 1;
    if (bus.p_valid && bus.p_dest != 0 && stall_m) err_m = 1;
    if (p_ok) begin
      load_m = 1; dest_m = bus.p_dest; in_m = bus.p_data;
    end else if (had) begin
      h = mq.pop_front();
      popped = 1;
      load_m = 1; dest_m = h.dest; in_m = h.data;
      if (!pend_m[h.dest]) err_m = 1;
      np[h.dest] = 1'b0;
    end else begin
      load_m = 0;
    end
    if (bus.issue_valid && bus.issue_dest != 0) np[bus.issue_dest] = 1'b1;
    pend_m = np;
    if (acc_m && bus.m_dest != 0) mq.push_back('{dest: bus.m_dest, data: bus.m_data});
    if (had && !popped) begin
      blk++;
      if (blk == SM) begin stall_m = 1; blk = 0; end
      else stall_m = 0;
    end else begin
      blk = 0; stall_m = 0;
    end
    live_m = 1;
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("rf_load", 32'(bus.rf_load), 32'(load_m));
    chk("rf_dest", 32'(bus.rf_dest), 32'(dest_m));
    chk("rf_in",   bus.rf_in, in_m);
    chk("m_ready", 32'(bus.m_ready), 32'(exp_mready()));
    chk("p_stall", 32'(bus.p_stall), 32'(stall_m));
    chk("pending", bus.pending, pend_m);
    chk("err",     32'(bus.err), 32'(err_m));
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_rf_load"}, 32'(bus.rf_load), 32'd0);
    chk({tag, "_rf_dest"}, 32'(bus.rf_dest), 32'd0);
    chk({tag, "_rf_in"},   bus.rf_in, 32'd0);
    chk({tag, "_pending"}, bus.pending, 32'd0);
    chk({tag, "_p_stall"}, 32'(bus.p_stall), 32'd0);
    chk({tag, "_err"},     32'(bus.err), 32'd0);
    chk({tag, "_m_ready"}, 32'(bus.m_ready), 32'd0);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_inputs();
    bus.p_valid = 0; bus.p_dest = '0; bus.p_data = '0;
    bus.m_valid = 0; bus.m_dest = '0; bus.m_data = '0;
    bus.issue_valid = 0; bus.issue_dest = '0;
  endtask

  task automatic issue(input logic [4:0] d);
    bus.issue_valid = 1; bus.issue_dest = d;
    tick();
    bus.issue_valid = 0; bus.issue_dest = '0;
  endtask

  // ---------------- stimulus ----------------
  logic [4:0] sends[$];
  logic [4:0] seq[$];
  logic [4:0] d;
  int         k;
  bit         saw_full;

  initial begin
    idle_inputs();
    model_reset();

    // reset state, then release
    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("m_ready_before_edge", 32'(bus.m_ready), 32'd0);
    tick();
    chk("m_ready_after_edge", 32'(bus.m_ready), 32'd1);

    // P only
    bus.p_valid = 1; bus.p_dest = 5'd5; bus.p_data = 32'hDEADBEEF;
    tick();
    chk("p_only_load", 32'(bus.rf_load), 32'd1);
    chk("p_only_dest", 32'(bus.rf_dest), 32'd5);
    chk("p_only_data", bus.rf_in, 32'hDEADBEEF);
    chk("p_only_pending", bus.pending, 32'd0);
    idle_inputs();
    tick();

    // M only: issue 7, write 7 two cycles later
    issue(5'd7);
    chk("m_issue_pending", bus.pending, 32'h80);
    bus.m_valid = 1; bus.m_dest = 5'd7; bus.m_data = 32'h12;
    tick();
    bus.m_valid = 0;
    chk("m_lat_n1_load", 32'(bus.rf_load), 32'd0);
    tick();
    chk("m_lat_n2_load", 32'(bus.rf_load), 32'd1);
    chk("m_lat_n2_dest", 32'(bus.rf_dest), 32'd7);
    chk("m_lat_n2_data", bus.rf_in, 32'h12);
    chk("m_clear_pending", bus.pending, 32'd0);
    chk("m_err", 32'(bus.err), 32'd0);

    // Starvation: P continuously busy while dest 3 waits
    issue(5'd3);
    bus.p_valid = 1; bus.p_dest = 5'd9; bus.p_data = $urandom;
    bus.m_valid = 1; bus.m_dest = 5'd3; bus.m_data = 32'h33;
    tick();
    bus.m_valid = 0;
    k = 0;
    while (bus.p_stall !== 1'b1 && k < 20) begin
      bus.p_data = $urandom;
      tick();
      k++;
    end
    chk("starve_cycles", 32'(k), 32'(SM));
    bus.p_valid = 0;
    tick();
    chk("starve_m_load", 32'(bus.rf_load), 32'd1);
    chk("starve_m_dest", 32'(bus.rf_dest), 32'd3);
    chk("starve_m_data", bus.rf_in, 32'h33);
    bus.p_valid = 1; bus.p_data = 32'h0000_9999;
    tick();
    chk("starve_p_resume", 32'(bus.rf_dest), 32'd9);
    chk("starve_p_data", bus.rf_in, 32'h0000_9999);
    idle_inputs();
    tick();

    // Full FIFO: three M writes against a busy pipeline, order kept
    issue(5'd10); issue(5'd11); issue(5'd12);
    sends.delete(); seq.delete();
    sends.push_back(5'd10); sends.push_back(5'd11); sends.push_back(5'd12);
    saw_full = 0;
    for (int i = 0; i < 40; i++) begin
      bus.p_valid = (i < 15) && !stall_m;
      bus.p_dest  = 5'd9;
      bus.p_data  = $urandom;
      bus.m_valid = sends.size() > 0;
      bus.m_dest  = (sends.size() > 0) ? sends[0] : 5'd0;
      bus.m_data  = 32'hA000 + 32'(bus.m_dest);
      tick();
      if (acc_m && bus.m_valid) void'(sends.pop_front());
      if (bus.m_ready === 1'b0) saw_full = 1;
      if (bus.rf_load === 1'b1 && bus.rf_dest >= 5'd10 && bus.rf_dest <= 5'd12) begin
        seq.push_back(bus.rf_dest);
        chk("full_m_data", bus.rf_in, 32'hA000 + 32'(bus.rf_dest));
      end
    end
    chk("full_seen", 32'(saw_full), 32'd1);
    chk("full_count", 32'(seq.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      chk("full_order", (i < seq.size()) ? 32'(seq[i]) : 32'hFFFF, 32'(10 + i));
    idle_inputs();
    tick();

    // Randomized legal traffic against the model
    sends.delete();
    for (int c = 0; c < 600; c++) begin
      bus.p_valid = !stall_m && ($urandom_range(0, 1) == 1);
      bus.p_dest  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      bus.p_data  = $urandom;
      bus.issue_valid = 0; bus.issue_dest = '0;
      if ($urandom_range(0, 3) == 0) begin
        d = 5'($urandom_range(1, 31));
        if (!pend_m[d]) begin bus.issue_valid = 1; bus.issue_dest = d; end
      end
      if (sends.size() > 0 && ((bus.m_valid && bus.m_dest != 0) || $urandom_range(0, 2) != 0)) begin
        bus.m_valid = 1; bus.m_dest = sends[0]; bus.m_data = $urandom;
      end else if ($urandom_range(0, 9) == 0) begin
        bus.m_valid = 1; bus.m_dest = 5'd0; bus.m_data = $urandom;
      end else begin
        bus.m_valid = 0;
      end
      tick();
      if (acc_m && bus.m_valid && bus.m_dest != 0) void'(sends.pop_front());
      if (bus.issue_valid) sends.push_back(bus.issue_dest);
    end
    // drain everything still owed
    idle_inputs();
    for (int c = 0; c < 100 && (sends.size() > 0 || mq.size() > 0); c++) begin
      bus.m_valid = sends.size() > 0;
      bus.m_dest  = (sends.size() > 0) ? sends[0] : 5'd0;
      bus.m_data  = $urandom;
      tick();
      if (acc_m && bus.m_valid) void'(sends.pop_front());
    end
    idle_inputs();
    tick();
    chk("rand_drained_pending", bus.pending, 32'd0);
    chk("rand_err_clean", 32'(bus.err), 32'd0);
    chk("rand_idle_load", 32'(bus.rf_load), 32'd0);

    // dest=0 on both sides never writes
    bus.p_valid = 1; bus.p_dest = 5'd0; bus.p_data = 32'h5555;
    tick();
    chk("p_dest0_load", 32'(bus.rf_load), 32'd0);
    idle_inputs();
    bus.m_valid = 1; bus.m_dest = 5'd0; bus.m_data = 32'h6666;
    tick();
    bus.m_valid = 0;
    tick();
    chk("m_dest0_load", 32'(bus.rf_load), 32'd0);
    chk("m_dest0_err", 32'(bus.err), 32'd0);

    // P asserted during p_stall: M head written, P dropped, err sticky
    issue(5'd6);
    bus.p_valid = 1; bus.p_dest = 5'd9; bus.p_data = $urandom;
    bus.m_valid = 1; bus.m_dest = 5'd6; bus.m_data = 32'h66;
    tick();
    bus.m_valid = 0;
    k = 0;
    while (bus.p_stall !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk("viol_stall_seen", 32'(bus.p_stall), 32'd1);
    bus.p_dest = 5'd13; bus.p_data = 32'hBAD;
    tick();
    chk("viol_m_dest", 32'(bus.rf_dest), 32'd6);
    chk("viol_m_data", bus.rf_in, 32'h66);
    chk("viol_err", 32'(bus.err), 32'd1);
    idle_inputs();
    tick();
    chk("viol_err_sticky", 32'(bus.err), 32'd1);

    // Reset mid-operation with a full FIFO and pending = 0x88
    issue(5'd3); issue(5'd7);
    bus.p_valid = 1; bus.p_dest = 5'd9; bus.p_data = $urandom;
    bus.m_valid = 1; bus.m_dest = 5'd3; bus.m_data = 32'h3;
    tick();
    bus.m_dest = 5'd7; bus.m_data = 32'h7;
    tick();
    idle_inputs();
    chk("pre_reset_pending", bus.pending, 32'h88);
    chk("pre_reset_full", 32'(bus.m_ready), 32'd0);
    #2 rst_n = 0;
    #1;
    check_reset_values("async_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("post_reset_no_load", 32'(bus.rf_load), 32'd0);
    end
    chk("post_reset_pending", bus.pending, 32'd0);

    // issue to an already pending register
    issue(5'd4);
    chk("dup_err_before", 32'(bus.err), 32'd0);
    issue(5'd4);
    chk("dup_err_after", 32'(bus.err), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, meaning consecutive blocked cycles of a buffered M write before the P requester is throttled (range 1..15).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have ports p_valid/p_dest/p_data  input  1/5/32  pipeline writeback request; no backpressure.
REQ-005 SHALL have ports m_valid/m_dest/m_data  input  1/5/32  multi-cycle unit writeback request.
REQ-006 SHALL have port m_ready  output  1  M request accepted when m_valid && m_ready at posedge.
REQ-007 SHALL have ports issue_valid/issue_dest  input  1/5  M operation issued; marks dest pending.
REQ-008 SHALL have port pending  output  32  per-register outstanding-M-write mask; bit 0 constant 0.
REQ-009 SHALL have port p_stall  output  1  registered; pipeline SHALL hold p_valid=0 in any cycle p_stall=1.
REQ-010 SHALL have ports rf_load/rf_dest/rf_in  output  1/5/32  register file write port, all registered.
REQ-011 SHALL have port err  output  1  sticky protocol-violation flag.

Function
REQ-012 SHALL buffer accepted M requests in a 2-entry FIFO; m_ready = !full (combinational from registered count).
REQ-013 SHALL drop M requests with m_dest=0 on acceptance (m_ready honoured, no push, no pending clear).
REQ-014 SHALL ignore P requests with p_dest=0 (no rf write).
REQ-015 SHALL select per cycle: P if p_valid && p_dest!=0 && !p_stall, else FIFO head if non-empty, else idle.
REQ-016 SHALL register the selected write: rf_load/rf_dest/rf_in valid the cycle after selection; P latency 1 cycle, M latency min 2 cycles (push N, select N+1, rf_load N+2).
REQ-017 SHALL keep rf_dest/rf_in at last value and rf_load=0 when idle.
REQ-018 SHALL pop the FIFO head exactly in the cycle it is selected; simultaneous push and pop on a full FIFO SHALL NOT occur (m_ready=0 when full, even if popping).
REQ-019 SHALL count consecutive cycles with FIFO non-empty and head not selected; reset counter on any pop or when empty.
REQ-020 SHALL assert p_stall for exactly one cycle when counter reaches STARVE_MAX, then clear counter; in that cycle the head SHALL be selected.
REQ-021 SHALL, if p_valid=1 (p_dest!=0) while p_stall=1, write the M head, discard P, set err.
REQ-022 SHALL set pending[issue_dest] on issue_valid with issue_dest!=0.
REQ-023 SHALL clear pending[d] in the cycle rf_load=1 for an M-sourced write to d.
REQ-024 SHALL give set priority over clear when both target the same bit in one cycle.
REQ-025 SHALL set err if issue_valid targets an already pending register, or an M write commits to a non-pending register.
REQ-026 SHALL NOT alter pending on P-sourced writes.

Reset
REQ-027 SHALL on rst_n=0 immediately force: FIFO empty, counter 0, pending=0, p_stall=0, rf_load=0, rf_dest=0, rf_in=0, err=0, m_ready=0.
REQ-028 SHALL drive m_ready=1 from the first posedge after rst_n deasserts; reset mid-operation SHALL discard buffered M writes without any rf_load.

Verification
REQ-029 P only: p_valid, dest=5, data=0xDEADBEEF at cycle N -> rf_load=1, rf_dest=5, rf_in=0xDEADBEEF at N+1; pending unchanged.
REQ-030 M only: issue dest=7; m_valid dest=7 data=0x12 at N -> rf_load at N+2 with dest 7, pending[7] clears same cycle; err=0.
REQ-031 Starvation: FIFO holds dest=3, p_valid continuous, STARVE_MAX=4 -> p_stall=1 one cycle after 4 blocked cycles, M write to 3 follows, P writes resume.
REQ-032 Full: two M pushes while p_valid busy -> m_ready=0; third m_valid held until a pop; pushes never lost, order preserved.
REQ-033 Violations: p_valid during p_stall -> P dropped, err=1 sticky; issue to pending reg -> err=1; dest=0 writes on either side -> no rf_load.
REQ-034 Reset mid-operation: rst_n low with FIFO full and pending=0x00000088 -> all outputs per REQ-027 asynchronously, no rf_load after release.
